// File: rtl/lcd_pattern_gen.sv
// LCD test-pattern generator: programs the CASET/RASET/RAMWR window, then
// streams H_RES x V_RES RGB565 pixels over the 9-bit {dc, byte} write port.
module lcd_pattern_gen #(
    parameter int unsigned H_RES       = 240,
    parameter int unsigned V_RES       = 320,
    parameter int unsigned NUM_BARS    = 4,
    parameter int unsigned CHECK_SHIFT = 4
) (
    input  logic        clk_50MHz,
    input  logic        rst,
    input  logic        init_done,
    input  logic        start,
    input  logic        auto_repeat,
    input  logic [1:0]  mode,
    input  logic [15:0] fg_color,
    input  logic        wr_done,
    output logic [8:0]  data,
    output logic        en_write,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  frame_count
);

    localparam int unsigned XW         = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int unsigned YW         = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int unsigned BAND_H_RAW = V_RES / NUM_BARS;
    localparam int unsigned BAND_H     = (BAND_H_RAW == 0) ? 1 : BAND_H_RAW;
    localparam int unsigned CMD_LAST   = 10;

    localparam logic [15:0]   XE        = 16'(H_RES - 1);
    localparam logic [15:0]   YE        = 16'(V_RES - 1);
    localparam logic [XW-1:0] X_LAST    = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(V_RES - 1);
    localparam logic [YW-1:0] BAND_LAST = YW'(BAND_H - 1);
    localparam logic [2:0]    BAR_LAST  = 3'(NUM_BARS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_PIX_HI,
        S_PIX_LO,
        S_DONE
    } state_t;

    state_t        state, state_n;
    logic [3:0]    cmd_idx, cmd_idx_n;
    logic [XW-1:0] x, x_n;
    logic [YW-1:0] y, y_n;
    logic [2:0]    band_idx, band_n;
    logic [YW-1:0] row_in_band, rib_n;
    logic [1:0]    mode_q, mode_n;
    logic [15:0]   fg_q, fg_n;
    logic [15:0]   color_q, color_n;
    logic [8:0]    data_n;
    logic          en_n;
    logic          busy_n;
    logic          fd_n;
    logic [7:0]    fc_n;
    logic [15:0]   pix_c;
    logic [15:0]   xe_c;
    logic [15:0]   ye_c;

    // Window-setup byte sequence, indexed by cmd_idx.
    function automatic logic [8:0] cmd_byte(input logic [3:0] idx);
        logic [8:0] b;
        b = 9'h000;
        case (idx)
            4'd0:    b = 9'h02A;
            4'd1:    b = 9'h100;
            4'd2:    b = 9'h100;
            4'd3:    b = {1'b1, XE[15:8]};
            4'd4:    b = {1'b1, XE[7:0]};
            4'd5:    b = 9'h02B;
            4'd6:    b = 9'h100;
            4'd7:    b = 9'h100;
            4'd8:    b = {1'b1, YE[15:8]};
            4'd9:    b = {1'b1, YE[7:0]};
            4'd10:   b = 9'h02C;
            default: b = 9'h000;
        endcase
        return b;
    endfunction

    // Colour-bar palette.
    function automatic logic [15:0] bar_color(input logic [2:0] b);
        logic [15:0] c;
        c = 16'h0000;
        case (b)
            3'd0:    c = 16'hF800;
            3'd1:    c = 16'h07E0;
            3'd2:    c = 16'h001F;
            3'd3:    c = 16'hFFFF;
            3'd4:    c = 16'h0000;
            3'd5:    c = 16'hFFE0;
            3'd6:    c = 16'h07FF;
            default: c = 16'hF81F;
        endcase
        return c;
    endfunction

    // Pixel colour from the current position and the latched configuration.
    always_comb begin
        xe_c  = 16'(x);
        ye_c  = 16'(y);
        pix_c = fg_q;
        case (mode_q)
            2'd0:    pix_c = fg_q;
            2'd1:    pix_c = bar_color(band_idx);
            2'd2:    pix_c = ((((xe_c ^ ye_c) >> CHECK_SHIFT) & 16'd1) != 16'd0) ? ~fg_q : fg_q;
            default: pix_c = {xe_c[7:3], ye_c[8:3], ~xe_c[7:3]};
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n   = state;
        cmd_idx_n = cmd_idx;
        x_n       = x;
        y_n       = y;
        band_n    = band_idx;
        rib_n     = row_in_band;
        mode_n    = mode_q;
        fg_n      = fg_q;
        color_n   = color_q;
        data_n    = data;
        en_n      = en_write;
        busy_n    = busy;
        fd_n      = 1'b0;
        fc_n      = frame_count;

        case (state)
            S_IDLE: begin
                en_n = 1'b0;
                if (start && init_done) begin
                    state_n   = S_CMD;
                    busy_n    = 1'b1;
                    mode_n    = mode;
                    fg_n      = fg_color;
                    cmd_idx_n = 4'd0;
                    x_n       = '0;
                    y_n       = '0;
                    band_n    = 3'd0;
                    rib_n     = '0;
                end
            end

            S_CMD: begin
                if (!en_write) begin
                    en_n   = 1'b1;
                    data_n = cmd_byte(cmd_idx);
                end else if (wr_done) begin
                    en_n = 1'b0;
                    if (cmd_idx == 4'(CMD_LAST)) begin
                        state_n = S_PIX_HI;
                    end else begin
                        cmd_idx_n = cmd_idx + 4'd1;
                    end
                end
            end

            S_PIX_HI: begin
                if (!en_write) begin
                    en_n    = 1'b1;
                    data_n  = {1'b1, pix_c[15:8]};
                    color_n = pix_c;
                end else if (wr_done) begin
                    en_n    = 1'b0;
                    state_n = S_PIX_LO;
                end
            end

            S_PIX_LO: begin
                if (!en_write) begin
                    en_n   = 1'b1;
                    data_n = {1'b1, color_q[7:0]};
                end else if (wr_done) begin
                    en_n = 1'b0;
                    if (x == X_LAST) begin
                        x_n = '0;
                        if (y == Y_LAST) begin
                            state_n = S_DONE;
                            fd_n    = 1'b1;
                            fc_n    = frame_count + 8'd1;
                        end else begin
                            state_n = S_PIX_HI;
                            y_n     = y + YW'(1);
                            // Band advances on a row count; the last band keeps the remainder.
                            if ((band_idx != BAR_LAST) && (row_in_band == BAND_LAST)) begin
                                band_n = band_idx + 3'd1;
                                rib_n  = '0;
                            end else begin
                                rib_n = row_in_band + YW'(1);
                            end
                        end
                    end else begin
                        state_n = S_PIX_HI;
                        x_n     = x + XW'(1);
                    end
                end
            end

            S_DONE: begin
                en_n = 1'b0;
                if (auto_repeat) begin
                    state_n   = S_CMD;
                    mode_n    = mode;
                    fg_n      = fg_color;
                    cmd_idx_n = 4'd0;
                    x_n       = '0;
                    y_n       = '0;
                    band_n    = 3'd0;
                    rib_n     = '0;
                end else begin
                    state_n = S_IDLE;
                    busy_n  = 1'b0;
                end
            end

            default: begin
                state_n = S_IDLE;
                en_n    = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            state       <= S_IDLE;
            cmd_idx     <= 4'd0;
            x           <= '0;
            y           <= '0;
            band_idx    <= 3'd0;
            row_in_band <= '0;
            mode_q      <= 2'd0;
            fg_q        <= 16'h0000;
            color_q     <= 16'h0000;
            data        <= 9'h000;
            en_write    <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            state       <= state_n;
            cmd_idx     <= cmd_idx_n;
            x           <= x_n;
            y           <= y_n;
            band_idx    <= band_n;
            row_in_band <= rib_n;
            mode_q      <= mode_n;
            fg_q        <= fg_n;
            color_q     <= color_n;
            data        <= data_n;
            en_write    <= en_n;
            busy        <= busy_n;
            frame_done  <= fd_n;
            frame_count <= fc_n;
        end
    end

endmodule
